// File: rtl/acq_write_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// Module   : acq_write_ctrl_pkg
// Brief    : Shared constants for the acquisition write controller, sample RAM
//            and read-side replay block.
// Revision : 1.0 - initial release
// =============================================================================
package acq_write_ctrl_pkg;

    localparam int c_ADDR_WIDTH = 9;
    localparam int c_DATA_WIDTH = 8;

    localparam int c_ST_WIDTH = 3;

    localparam logic [c_ST_WIDTH-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_ST_WIDTH-1:0] c_ST_PRE   = 3'd1;
    localparam logic [c_ST_WIDTH-1:0] c_ST_ARMED = 3'd2;
    localparam logic [c_ST_WIDTH-1:0] c_ST_POST  = 3'd3;
    localparam logic [c_ST_WIDTH-1:0] c_ST_DONE  = 3'd4;

    // States in which incoming valid samples are written to the RAM.
    function automatic logic fn_is_capturing(input logic [c_ST_WIDTH-1:0] i_state);
        return (i_state == c_ST_PRE) || (i_state == c_ST_ARMED) || (i_state == c_ST_POST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acq_write_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : acq_write_ctrl
// Brief    : Circular pre/post-trigger capture controller driving the write
//            port of the dual-port sample RAM; reports the oldest sample address.
// Revision : 1.0 - initial release
// =============================================================================
module acq_write_ctrl
    import acq_write_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  trigger,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  write_en,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] start_addr
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [c_ST_WIDTH-1:0] r_state;
    logic [c_ST_WIDTH-1:0] w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_pre_cnt;
    logic [ADDR_WIDTH:0]   r_post_cnt;
    logic [ADDR_WIDTH-1:0] r_pretrig_len;
    logic [ADDR_WIDTH-1:0] r_start_addr;

    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_write_en;

    logic                  w_capturing;
    logic                  w_start_acc;
    logic                  w_wr;
    logic                  w_pre_last;
    logic [ADDR_WIDTH:0]   w_post_inc;
    logic [ADDR_WIDTH:0]   w_post_target;
    logic                  w_post_last;

    // Abort takes priority over start, even when abort itself has no effect.
    assign w_start_acc   = start && !abort &&
                           ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_wr          = w_capturing && sample_valid && !abort;
    assign w_pre_last    = ((r_pre_cnt + 1'b1) == r_pretrig_len);
    assign w_post_inc    = r_post_cnt + 1'b1;
    assign w_post_target = c_DEPTH - {1'b0, r_pretrig_len};
    assign w_post_last   = (w_post_inc == w_post_target);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (w_start_acc) begin
                    w_state_nxt = (pretrig_len == '0) ? c_ST_ARMED : c_ST_PRE;
                end
            end
            c_ST_PRE: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (sample_valid && w_pre_last) begin
                    w_state_nxt = c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                // post_cnt is still zero here, so w_post_last flags a one-sample post window.
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (sample_valid && trigger) begin
                    w_state_nxt = w_post_last ? c_ST_DONE : c_ST_POST;
                end
            end
            c_ST_POST: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (sample_valid && w_post_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_capturing = fn_is_capturing(r_state);
        busy        = w_capturing;
        done        = (r_state == c_ST_DONE);
    end

    // -------------------------------------------------------------------------
    // Pointer and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_pretrig_len <= '0;
            r_start_addr  <= '0;
        end else if (w_start_acc) begin
            r_pretrig_len <= pretrig_len;
            r_wr_ptr      <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
        end else if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_state == c_ST_PRE) begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
            if ((r_state == c_ST_POST) || ((r_state == c_ST_ARMED) && trigger)) begin
                r_post_cnt <= w_post_inc;
            end
            // Pointer after the final write lands on the oldest sample in the buffer.
            if (w_state_nxt == c_ST_DONE) begin
                r_start_addr <= r_wr_ptr + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port, one cycle behind the accepted sample
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write_en <= 1'b0;
            r_waddr    <= '0;
            r_din      <= '0;
        end else begin
            r_write_en <= w_wr;
            if (w_wr) begin
                r_waddr <= r_wr_ptr;
                r_din   <= sample;
            end
        end
    end

    assign waddr      = r_waddr;
    assign din        = r_din;
    assign write_en   = r_write_en;
    assign start_addr = r_start_addr;

endmodule
`default_nettype wire

// File: tb/tb_acq_write_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_acq_write_ctrl
// Brief    : Scenario bench for acq_write_ctrl with a write-port scoreboard.
// Revision : 1.0 - initial release
// =============================================================================
module tb_acq_write_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] pretrig_len;
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic          trigger;
    logic [AW-1:0] waddr;
    logic [DW-1:0] din;
    logic          write_en;
    logic          busy;
    logic          done;
    logic [AW-1:0] start_addr;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           sb[$];
    logic [DW-1:0] ram [16];
    int            n_checks = 0;
    int            n_fail   = 0;

    acq_write_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .pretrig_len  (pretrig_len),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trigger      (trigger),
        .waddr        (waddr),
        .din          (din),
        .write_en     (write_en),
        .busy         (busy),
        .done         (done),
        .start_addr   (start_addr)
    );

    always #5 clk = ~clk;

    // Write-port scoreboard and shadow RAM.
    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            wr_t e;
            ram[waddr] = din;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: waddr=%0d din=%0d, required no write", waddr, din);
            end else begin
                e = sb.pop_front();
                if ({waddr, din} !== {e.a, e.d}) begin
                    n_fail++;
                    $display("FAIL write_port: waddr=%0d din=%0d, required waddr=%0d din=%0d",
                             waddr, din, e.a, e.d);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] s, input logic t,
                       input logic st, input logic ab, input logic [AW-1:0] pl);
        sample_valid = v;
        sample       = s;
        trigger      = t;
        start        = st;
        abort        = ab;
        pretrig_len  = pl;
        @(negedge clk);
    endtask

    task automatic push(input int a, input int d);
        wr_t e;
        e.a = AW'(a);
        e.d = DW'(d);
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({busy, done, write_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/we=%b, required 000", {busy, done, write_en});
        end
        n_checks++;
        if ({waddr, din, start_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: waddr=%0d din=%0d start_addr=%0d, required 0 0 0",
                     waddr, din, start_addr);
        end
        rst_n = 1'b1;
        cyc(1, 8'h55, 1, 0, 0, 0);
        n_checks++;
        if (write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_write: write_en=%b, required 0", write_en);
        end
    endtask

    task automatic test_basic;
        for (int v = 0; v <= 21; v++) push(v % 16, v);
        cyc(0, 0, 0, 1, 0, 4);
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_start: busy/done=%b, required 10", {busy, done});
        end
        for (int v = 0; v < 26; v++) begin
            cyc(1, DW'(v), v == 10, 0, 0, 0);
            if (v == 20) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_early_done: done=%b, required 0", done);
                end
            end
            if (v == 21) begin
                n_checks++;
                if ({busy, done, start_addr} !== {2'b01, 4'd6}) begin
                    n_fail++;
                    $display("FAIL basic_done: busy=%b done=%b start_addr=%0d, required 0 1 6",
                             busy, done, start_addr);
                end
            end
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_missing: %0d writes outstanding, required 0", sb.size());
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (ram[(6 + i) % 16] !== DW'(6 + i)) begin
                n_fail++;
                $display("FAIL basic_ram: addr %0d holds %0d, required %0d",
                         (6 + i) % 16, ram[(6 + i) % 16], 6 + i);
            end
        end
    endtask

    task automatic test_early_trigger;
        for (int v = 0; v <= 19; v++) push(v % 16, v);
        cyc(0, 0, 0, 1, 0, 4);
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL early_restart: busy/done=%b, required 10", {busy, done});
        end
        for (int v = 0; v < 24; v++) begin
            cyc(1, DW'(v), (v >= 1 && v <= 3) || v == 8, 0, 0, 0);
            if (v == 19) begin
                n_checks++;
                if ({done, start_addr} !== {1'b1, 4'd4}) begin
                    n_fail++;
                    $display("FAIL early_done: done=%b start_addr=%0d, required 1 4", done, start_addr);
                end
            end
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL early_missing: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_gapped;
        for (int k = 0; k <= 17; k++) push(k % 16, 2 * k);
        cyc(0, 0, 0, 1, 0, 2);
        for (int i = 0; i < 40; i++) begin
            cyc(i % 2 == 0, DW'(i), i == 7 || i == 8, 0, 0, 0);
            if (i == 7) begin
                n_checks++;
                if ({write_en, busy} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL gap_invalid: write_en=%b busy=%b, required 0 1", write_en, busy);
                end
            end
            if (i == 34) begin
                n_checks++;
                if ({done, start_addr} !== {1'b1, 4'd2}) begin
                    n_fail++;
                    $display("FAIL gap_done: done=%b start_addr=%0d, required 1 2", done, start_addr);
                end
            end
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL gap_missing: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_boundary_zero;
        for (int v = 0; v <= 15; v++) push(v, v + 32);
        cyc(0, 0, 0, 1, 0, 0);
        for (int v = 0; v < 20; v++) begin
            cyc(1, DW'(v + 32), v == 0, 0, 0, 0);
            if (v == 14) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL len0_early_done: done=%b, required 0", done);
                end
            end
            if (v == 15) begin
                n_checks++;
                if ({done, start_addr} !== {1'b1, 4'd0}) begin
                    n_fail++;
                    $display("FAIL len0_done: done=%b start_addr=%0d, required 1 0", done, start_addr);
                end
            end
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL len0_missing: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_boundary_max;
        for (int v = 0; v <= 17; v++) push(v % 16, v);
        cyc(0, 0, 0, 1, 0, 15);
        for (int v = 0; v < 21; v++) begin
            cyc(1, DW'(v), v >= 17, 0, 0, 0);
            if (v == 16) begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL len15_early_done: done=%b, required 0", done);
                end
            end
            if (v == 17) begin
                n_checks++;
                if ({busy, done, start_addr} !== {2'b01, 4'd2}) begin
                    n_fail++;
                    $display("FAIL len15_done: busy=%b done=%b start_addr=%0d, required 0 1 2",
                             busy, done, start_addr);
                end
            end
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL len15_missing: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_abort;
        for (int v = 0; v <= 5; v++) push(v, v + 64);
        cyc(0, 0, 0, 1, 0, 2);
        for (int v = 0; v <= 5; v++) cyc(1, DW'(v + 64), 0, 0, 0, 0);
        cyc(1, 8'd99, 1, 0, 1, 0);
        n_checks++;
        if ({write_en, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_armed: we/busy/done=%b, required 000", {write_en, busy, done});
        end
        for (int v = 0; v < 3; v++) cyc(1, 8'd77, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 3);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_beats_start: busy=%b, required 0", busy);
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL abort_missing: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        for (int v = 0; v <= 17; v++) push(v % 16, v);
        cyc(0, 0, 0, 1, 0, 4);
        for (int v = 0; v < 21; v++) begin
            cyc(1, DW'(v), v == 6, v == 12, 0, 0);
            if (v == 12) begin
                n_checks++;
                if ({busy, done} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL post_start_ignored: busy/done=%b, required 10", {busy, done});
                end
            end
            if (v == 17) begin
                n_checks++;
                if ({done, start_addr} !== {1'b1, 4'd2}) begin
                    n_fail++;
                    $display("FAIL b2b_done: done=%b start_addr=%0d, required 1 2", done, start_addr);
                end
            end
        end
        push(0, 100);
        cyc(0, 0, 0, 1, 0, 3);
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL restart_from_done: busy/done=%b, required 10", {busy, done});
        end
        cyc(1, 8'd100, 0, 0, 0, 0);
        cyc(1, 8'd101, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_missing: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_post;
        for (int v = 0; v <= 3; v++) push(v, v + 10);
        cyc(0, 0, 0, 1, 0, 1);
        for (int v = 0; v <= 3; v++) cyc(1, DW'(v + 10), v == 1, 0, 0, 0);
        rst_n = 1'b0;
        cyc(1, 8'd50, 1, 0, 0, 0);
        n_checks++;
        if ({write_en, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_flags: we/busy/done=%b, required 000", {write_en, busy, done});
        end
        n_checks++;
        if ({waddr, din, start_addr} !== '0) begin
            n_fail++;
            $display("FAIL midreset_regs: waddr=%0d din=%0d start_addr=%0d, required 0 0 0",
                     waddr, din, start_addr);
        end
        rst_n = 1'b1;
        cyc(1, 8'd51, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_missing: %0d writes outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        pretrig_len  = '0;
        sample_valid = 1'b0;
        sample       = '0;
        trigger      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_early_trigger();
        test_gapped();
        test_boundary_zero();
        test_boundary_max();
        test_abort();
        test_back_to_back();
        test_reset_mid_post();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
